// File: rtl/axi_rd_arb_2to1_if.sv
// AXI read-channel bundle (AR + R) shared by the arbiter's master ports and its slave port.
// Handshake rule: a transfer happens on a rising clk edge where valid and ready are both 1; valid never waits on ready.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

interface axi_rd_arb_2to1_if;
    logic                        arvalid;
    logic                        arready;
    logic [`AXI_ID_WIDTH-1:0]    arid;
    logic [`AXI_ADDR_WIDTH-1:0]  araddr;
    logic [`AXI_LEN_WIDTH-1:0]   arlen;
    logic [`AXI_SIZE_WIDTH-1:0]  arsize;
    logic [`AXI_BURST_WIDTH-1:0] arburst;
    logic                        rvalid;
    logic                        rready;
    logic [`AXI_ID_WIDTH-1:0]    rid;
    logic [`AXI_DATA_WIDTH-1:0]  rdata;
    logic [`AXI_RESP_WIDTH-1:0]  rresp;
    logic                        rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_rd_arb_2to1.sv
// Two-master to one-slave AXI read arbiter: grants one complete burst at a time
// (IDLE -> ADDR -> DATA), round-robin or fixed m0 priority selected by RR_EN.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module axi_rd_arb_2to1 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_rd_arb_2to1_if.slave      m0,
    axi_rd_arb_2to1_if.slave      m1,
    axi_rd_arb_2to1_if.master     s,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   gnt;
    logic   last_gnt;

    assign dbg_state = state;

    // last_gnt resets to m1 so that m0 wins the first contested round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.arvalid || m1.arvalid) begin
                        if (m0.arvalid && m1.arvalid)
                            gnt <= RR_EN ? ~last_gnt : 1'b0;
                        else
                            gnt <= m1.arvalid;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (s.arvalid && s.arready) begin
                        state    <= DATA;
                        last_gnt <= gnt;
                    end
                end
                DATA: begin
                    if (s.rvalid && s.rready && s.rlast)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forwarding is a pure mux on registered state/gnt; everything not routed is held at 0.
    always_comb begin
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        s.arvalid  = 1'b0;
        s.arid     = '0;
        s.araddr   = '0;
        s.arlen    = '0;
        s.arsize   = '0;
        s.arburst  = '0;
        s.rready   = 1'b0;
        m0.rvalid  = 1'b0;
        m0.rid     = '0;
        m0.rdata   = '0;
        m0.rresp   = '0;
        m0.rlast   = 1'b0;
        m1.rvalid  = 1'b0;
        m1.rid     = '0;
        m1.rdata   = '0;
        m1.rresp   = '0;
        m1.rlast   = 1'b0;
        case (state)
            ADDR: begin
                if (!gnt) begin
                    s.arvalid  = m0.arvalid;
                    s.arid     = m0.arid;
                    s.araddr   = m0.araddr;
                    s.arlen    = m0.arlen;
                    s.arsize   = m0.arsize;
                    s.arburst  = m0.arburst;
                    m0.arready = s.arready;
                end else begin
                    s.arvalid  = m1.arvalid;
                    s.arid     = m1.arid;
                    s.araddr   = m1.araddr;
                    s.arlen    = m1.arlen;
                    s.arsize   = m1.arsize;
                    s.arburst  = m1.arburst;
                    m1.arready = s.arready;
                end
            end
            DATA: begin
                if (!gnt) begin
                    m0.rvalid = s.rvalid;
                    m0.rid    = s.rid;
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                    m0.rlast  = s.rlast;
                    s.rready  = m0.rready;
                end else begin
                    m1.rvalid = s.rvalid;
                    m1.rid    = s.rid;
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                    m1.rlast  = s.rlast;
                    s.rready  = m1.rready;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arb_2to1.sv
// Bench for axi_rd_arb_2to1: a round-robin instance with a burst-capable slave model,
// plus a fixed-priority instance with both masters requesting continuously.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module tb_axi_rd_arb_2to1;
    localparam int W = 2 + `AXI_ID_WIDTH + `AXI_DATA_WIDTH;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    logic [W-1:0] exp_q[$];
    logic hs0 = 1'b0;
    logic hs1 = 1'b0;
    logic tog1 = 1'b0;
    logic s_arready_en = 1'b1;
    logic b_req = 1'b0;

    // ---------------- round-robin instance ----------------
    axi_rd_arb_2to1_if a_m0 ();
    axi_rd_arb_2to1_if a_m1 ();
    axi_rd_arb_2to1_if a_s ();
    logic [1:0] a_dbg;

    axi_rd_arb_2to1 #(.RR_EN(1'b1)) u_dut_rr (
        .clk(clk), .rst_n(rst_n), .m0(a_m0), .m1(a_m1), .s(a_s), .dbg_state(a_dbg)
    );

    logic                       sl_busy;
    logic [`AXI_LEN_WIDTH-1:0]  sl_len, sl_idx;
    logic [`AXI_ADDR_WIDTH-1:0] sl_addr;
    logic [`AXI_ID_WIDTH-1:0]   sl_id;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_busy <= 1'b0;
            sl_len  <= '0;
            sl_idx  <= '0;
            sl_addr <= '0;
            sl_id   <= '0;
        end else if (a_s.arvalid && a_s.arready) begin
            sl_busy <= 1'b1;
            sl_len  <= a_s.arlen;
            sl_idx  <= '0;
            sl_addr <= a_s.araddr;
            sl_id   <= a_s.arid;
        end else if (a_s.rvalid && a_s.rready) begin
            if (sl_idx == sl_len) sl_busy <= 1'b0;
            else sl_idx <= sl_idx + 1'b1;
        end
    end

    assign a_s.arready = s_arready_en;
    assign a_s.rvalid  = sl_busy;
    assign a_s.rid     = sl_id;
    assign a_s.rdata   = `AXI_DATA_WIDTH'(sl_addr + `AXI_ADDR_WIDTH'(sl_idx));
    assign a_s.rresp   = '0;
    assign a_s.rlast   = sl_busy && (sl_idx == sl_len);

    // ---------------- fixed-priority instance ----------------
    axi_rd_arb_2to1_if b_m0 ();
    axi_rd_arb_2to1_if b_m1 ();
    axi_rd_arb_2to1_if b_s ();
    logic [1:0] b_dbg;
    logic       b_busy;

    axi_rd_arb_2to1 #(.RR_EN(1'b0)) u_dut_fp (
        .clk(clk), .rst_n(rst_n), .m0(b_m0), .m1(b_m1), .s(b_s), .dbg_state(b_dbg)
    );

    assign b_m0.arvalid = b_req;
    assign b_m0.arid    = `AXI_ID_WIDTH'(0);
    assign b_m0.araddr  = '0;
    assign b_m0.arlen   = '0;
    assign b_m0.arsize  = '0;
    assign b_m0.arburst = '0;
    assign b_m0.rready  = 1'b1;
    assign b_m1.arvalid = b_req;
    assign b_m1.arid    = `AXI_ID_WIDTH'(1);
    assign b_m1.araddr  = '0;
    assign b_m1.arlen   = '0;
    assign b_m1.arsize  = '0;
    assign b_m1.arburst = '0;
    assign b_m1.rready  = 1'b1;
    assign b_s.arready  = 1'b1;
    assign b_s.rvalid   = b_busy;
    assign b_s.rid      = '0;
    assign b_s.rdata    = '0;
    assign b_s.rresp    = '0;
    assign b_s.rlast    = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_busy <= 1'b0;
        else if (b_s.arvalid && b_s.arready) b_busy <= 1'b1;
        else if (b_s.rvalid && b_s.rready) b_busy <= 1'b0;
    end

    // ---------------- checking and driver tasks ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take_beat(input logic m, input logic l, input logic [`AXI_ID_WIDTH-1:0] id,
                             input logic [`AXI_DATA_WIDTH-1:0] d);
        logic [W-1:0] e;
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", 64'({m, l, id, d}), 64'(e));
        end
        pops++;
    endtask

    task automatic neg_half();
        @(negedge clk);
        hs0 = a_m0.arvalid && a_m0.arready;
        hs1 = a_m1.arvalid && a_m1.arready;
        if (a_m0.rvalid && a_m0.rready) take_beat(1'b0, a_m0.rlast, a_m0.rid, a_m0.rdata);
        if (a_m1.rvalid && a_m1.rready) take_beat(1'b1, a_m1.rlast, a_m1.rid, a_m1.rdata);
    endtask

    task automatic pos_half();
        @(posedge clk);
        #1;
        if (hs0) a_m0.arvalid = 1'b0;
        if (hs1) a_m1.arvalid = 1'b0;
        if (tog1) a_m1.rready = ~a_m1.rready;
    endtask

    task automatic start_ar(input logic m, input logic [`AXI_ID_WIDTH-1:0] id,
                            input logic [`AXI_ADDR_WIDTH-1:0] addr, input logic [`AXI_LEN_WIDTH-1:0] len);
        logic [`AXI_DATA_WIDTH-1:0] d;
        logic l;
        if (!m) begin
            a_m0.arid = id; a_m0.araddr = addr; a_m0.arlen = len;
            a_m0.arsize = 3'd2; a_m0.arburst = 2'b01; a_m0.arvalid = 1'b1;
        end else begin
            a_m1.arid = id; a_m1.araddr = addr; a_m1.arlen = len;
            a_m1.arsize = 3'd2; a_m1.arburst = 2'b01; a_m1.arvalid = 1'b1;
        end
        for (int i = 0; i <= int'(len); i++) begin
            d = `AXI_DATA_WIDTH'(addr + `AXI_ADDR_WIDTH'(i));
            l = (i == int'(len));
            exp_q.push_back({m, l, id, d});
        end
    endtask

    task automatic drain(input int budget, input bit watch);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            neg_half();
            if (watch && exp_q.size() > 1) begin
                chk("m0_arready_held", 64'(a_m0.arready), 64'd0);
                if (a_dbg == ST_DATA) chk("s_rready_track", 64'(a_s.rready), 64'(a_m1.rready));
            end
            done = (exp_q.size() == 0) && (a_dbg == ST_IDLE) && !a_m0.arvalid && !a_m1.arvalid;
            pos_half();
        end
        chk("drain_done", 64'(done), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_m0_arready"}, 64'(a_m0.arready), 64'd0);
        chk({tag, "_m1_arready"}, 64'(a_m1.arready), 64'd0);
        chk({tag, "_s_arvalid"}, 64'(a_s.arvalid), 64'd0);
        chk({tag, "_s_araddr"}, 64'(a_s.araddr), 64'd0);
        chk({tag, "_s_rready"}, 64'(a_s.rready), 64'd0);
        chk({tag, "_m0_rvalid"}, 64'(a_m0.rvalid), 64'd0);
        chk({tag, "_m1_rvalid"}, 64'(a_m1.rvalid), 64'd0);
        chk({tag, "_m0_rdata"}, 64'(a_m0.rdata), 64'd0);
        chk({tag, "_state"}, 64'(a_dbg), 64'(ST_IDLE));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        exp_q.delete();
        a_m0.arvalid = 1'b0; a_m1.arvalid = 1'b0;
        a_m0.rready = 1'b1;  a_m1.rready = 1'b1;
        tog1 = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
        #1;
        chk_zero(tag);
        neg_half();
        pos_half();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int p0;
        int n;
        a_m0.arvalid = 1'b0; a_m0.arid = '0; a_m0.araddr = '0; a_m0.arlen = '0;
        a_m0.arsize = '0; a_m0.arburst = '0; a_m0.rready = 1'b1;
        a_m1.arvalid = 1'b0; a_m1.arid = '0; a_m1.araddr = '0; a_m1.arlen = '0;
        a_m1.arsize = '0; a_m1.arburst = '0; a_m1.rready = 1'b1;
        pos_half();
        do_reset("reset");

        // Single m0 read; s_arvalid appears one cycle after m0_arvalid.
        start_ar(1'b0, 4'd1, 32'h10, 8'd0);
        neg_half();
        chk("lat_s_arvalid_idle", 64'(a_s.arvalid), 64'd0);
        pos_half();
        neg_half();
        chk("lat_s_arvalid", 64'(a_s.arvalid), 64'd1);
        chk("lat_s_araddr", 64'(a_s.araddr), 64'h10);
        chk("lat_m0_arready", 64'(a_m0.arready), 64'd1);
        chk("lat_m1_arready", 64'(a_m1.arready), 64'd0);
        pos_half();
        drain(50, 1'b0);

        // m0 was last served, so a simultaneous request goes to m1 first.
        start_ar(1'b1, 4'd2, 32'h20, 8'd1);
        start_ar(1'b0, 4'd3, 32'h30, 8'd0);
        drain(80, 1'b0);

        // Fresh reset: simultaneous requests alternate m0, m1, m0, m1.
        do_reset("reset2");
        start_ar(1'b0, 4'd4, 32'h100, 8'd0);
        start_ar(1'b1, 4'd5, 32'h110, 8'd1);
        drain(80, 1'b0);
        start_ar(1'b0, 4'd6, 32'h120, 8'd0);
        start_ar(1'b1, 4'd7, 32'h130, 8'd0);
        drain(80, 1'b0);

        // m1 burst of 4 with toggling rready; m0 requests during it and must wait.
        start_ar(1'b1, 4'd8, 32'h200, 8'd3);
        tog1 = 1'b1;
        neg_half();
        pos_half();
        start_ar(1'b0, 4'd9, 32'h300, 8'd0);
        drain(120, 1'b1);
        tog1 = 1'b0;
        a_m1.rready = 1'b1;

        // Slave stalls AR for 5 cycles; forwarded AR must stay stable.
        s_arready_en = 1'b0;
        start_ar(1'b0, 4'd2, 32'h40, 8'd1);
        neg_half();
        pos_half();
        for (int i = 0; i < 5; i++) begin
            neg_half();
            chk("stall_s_arvalid", 64'(a_s.arvalid), 64'd1);
            chk("stall_s_araddr", 64'(a_s.araddr), 64'h40);
            chk("stall_s_arlen", 64'(a_s.arlen), 64'd1);
            chk("stall_s_arid", 64'(a_s.arid), 64'd2);
            chk("stall_m0_arready", 64'(a_m0.arready), 64'd0);
            pos_half();
        end
        s_arready_en = 1'b1;
        neg_half();
        chk("stall_release_arready", 64'(a_m0.arready), 64'd1);
        pos_half();
        neg_half();
        chk("stall_to_data", 64'(a_dbg), 64'(ST_DATA));
        pos_half();
        drain(50, 1'b0);

        // Reset during beat 2 of an 8-beat burst, then a fresh m1 request.
        start_ar(1'b0, 4'd7, 32'h500, 8'd7);
        p0 = pops;
        for (int i = 0; i < 40 && pops < p0 + 1; i++) begin
            neg_half();
            pos_half();
        end
        chk("midburst_beats_done", 64'(pops - p0), 64'd1);
        chk("midburst_beat2_live", 64'(a_m0.rvalid), 64'd1);
        do_reset("midburst_reset");
        start_ar(1'b1, 4'd6, 32'h600, 8'd1);
        drain(50, 1'b0);

        // Fixed priority with both masters always requesting: m0 takes every grant.
        b_req = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            neg_half();
            if (b_s.arvalid && b_s.arready) begin
                chk("fixed_gnt_id", 64'(b_s.arid), 64'd0);
                n++;
            end
            pos_half();
        end
        chk("fixed_gnt_count", 64'(n), 64'd4);
        b_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_rd_arb_2to1.md
Name: axi_rd_arb_2to1

Overview:
- Two-master to one-slave AXI read-channel arbiter. Lets the instruction-fetch port (m0) and the data-load port (m1) share the single AXI_ROM read slave.
- Sequences one complete burst at a time: arbitrate AR, forward AR, route R beats back to the granted master until rlast.
- Only one transaction is outstanding at any time, so no ID remapping is needed.

Parameters:
- RR_EN, 1, 1 = round-robin between m0/m1; 0 = fixed priority, m0 always wins.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- m0_arvalid / m1_arvalid  in  1  master AR valid
- m0_arready / m1_arready  out  1  master AR ready
- m0_arid / m1_arid  in  `AXI_ID_WIDTH  AR id
- m0_araddr / m1_araddr  in  `AXI_ADDR_WIDTH  AR address
- m0_arlen / m1_arlen  in  `AXI_LEN_WIDTH  burst length
- m0_arsize / m1_arsize  in  `AXI_SIZE_WIDTH  beat size
- m0_arburst / m1_arburst  in  `AXI_BURST_WIDTH  burst type
- m0_rvalid / m1_rvalid  out  1  R valid
- m0_rready / m1_rready  in  1  R ready
- m0_rid / m1_rid  out  `AXI_ID_WIDTH  R id
- m0_rdata / m1_rdata  out  `AXI_DATA_WIDTH  R data
- m0_rresp / m1_rresp  out  `AXI_RESP_WIDTH  R response
- m0_rlast / m1_rlast  out  1  R last
- s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst  out  as above  AR to slave
- s_arready  in  1  slave AR ready
- s_rvalid, s_rid, s_rdata, s_rresp, s_rlast  in  as above  R from slave
- s_rready  out  1  R ready to slave
- Slave lock/cache/prot/qos/region inputs are tied to 0 by the integrator.

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: state, gnt (0 = m0, 1 = m1), last_gnt.
- Reset (async, rst_n low):
  - state = IDLE, gnt = 0, last_gnt = 1, so m0 wins the first contest.
  - All outputs 0: every valid, every ready, and all forwarded buses.
- IDLE:
  - All m*_arready = 0 and s_arvalid = 0.
  - One request pending: gnt <= that master.
  - Both pending:
    - RR_EN = 1: gnt <= ~last_gnt.
    - RR_EN = 0: gnt <= 0.
  - Any request pending: state <= ADDR on the next edge.
  - Minimum latency: m_arvalid to s_arvalid is 1 cycle.
- ADDR:
  - s_ar* = granted master's ar* (combinational mux). s_arvalid = granted arvalid.
  - Granted arready = s_arready. Non-granted arready = 0.
  - On s_arvalid & s_arready: state <= DATA, last_gnt <= gnt.
  - If the granted master drops arvalid before handshake (protocol violation), the arbiter stays in ADDR; no special recovery.
- DATA:
  - s_r* routed to the granted master. Granted rvalid = s_rvalid. s_rready = granted rready.
  - Non-granted m*_rvalid = 0; its rdata/rid/rresp/rlast = 0.
  - On s_rvalid & s_rready & s_rlast: state <= IDLE.
  - The next grant decision happens in that IDLE cycle, giving 1 bubble cycle between bursts.
- Outside DATA: all m*_rvalid = 0 and s_rready = 0. Stray slave beats are stalled, not dropped.
- New requests during ADDR/DATA: held off (arready = 0) until back in IDLE. Grant never changes mid-burst.
- Simultaneous events:
  - rlast handshake and a new arvalid in the same cycle: the request is evaluated in the following IDLE cycle.
  - Both masters continuously requesting with RR_EN = 1: strict alternation m0, m1, m0, ...
- arlen = 0 (single beat): DATA exits on the first beat, since rlast must be 1.
- Reset mid-burst: immediate return to IDLE with outputs 0. The slave is reset in the same domain, so no drain is required.

Test Plan:
- Single m0 read, araddr = 0x10, arlen = 0 → s_arvalid 1 cycle after m0_arvalid with s_araddr = 0x10; m0 gets one beat, rlast = 1; m1_rvalid stays 0.
- m0 and m1 assert arvalid on the same cycle, RR_EN = 1, after reset → m0 served first, then m1. Repeat → m0, m1 alternate across 4 bursts.
- Same stimulus with RR_EN = 0 and m0 always requesting → m1 starves; m0 granted 4 of 4.
- m1 burst with arlen = 3 and m1_rready toggling 1,0,1,0,... → exactly 4 beats delivered in order; s_rready tracks m1_rready; no beat lost or duplicated; m0_arready = 0 throughout.
- s_arready held 0 for 5 cycles in ADDR → s_ar* stable and equal to the granted master's AR; handshake completes on the cycle s_arready rises.
- rst_n pulsed low during beat 2 of an arlen = 7 burst → all valids/readies 0 immediately; after release, a fresh m1 request is granted normally.
